// File: rtl/dual_input_debouncer_pkg.sv
// ---------------------------------------------------------------------------
// dual_input_debouncer_pkg
//   Shared constants for the dual-input debouncer:
//     - ST_IDLE / ST_COUNT : per-channel filter state encoding
//     - DEF_DEBOUNCE_CYCLES: default number of qualifying edges
//     - DEF_CNT_WIDTH      : default per-channel counter width
// ---------------------------------------------------------------------------
package dual_input_debouncer_pkg;

  // Filter state encoding, kept as plain constants so the state register
  // stays a bare logic vector for downstream tools.
  localparam logic ST_IDLE  = 1'b0;  // synchronized input agrees with output
  localparam logic ST_COUNT = 1'b1;  // disagreement seen, qualifying it

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_CNT_WIDTH       = 16;

endpackage : dual_input_debouncer_pkg

// File: rtl/dual_input_debouncer_channel.sv
// ---------------------------------------------------------------------------
// debounce_channel
//   One debounce lane: 2-flop synchronizer, then a counter filter that only
//   lets the output follow after DEBOUNCE_CYCLES consecutive edges of
//   disagreement. Any agreement clears the count, so glitches and bounces
//   never reach the output.
//
// Ports
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   i_raw   in   raw asynchronous level
//   o_level out  debounced, registered level
//   o_chg   out  one-cycle pulse in the cycle after o_level updates
//   o_sync  out  synchronized input (second synchronizer flop)
// ---------------------------------------------------------------------------
module debounce_channel
  import dual_input_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_WIDTH       = DEF_CNT_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_chg,
  output logic o_sync
);

  // Reject configurations whose terminal count cannot be held by the counter.
  if ((DEBOUNCE_CYCLES < 1) ||
      ((longint'(DEBOUNCE_CYCLES) - 1) >= (longint'(1) << CNT_WIDTH))) begin : g_bad_param
    $error("debounce_channel: DEBOUNCE_CYCLES=%0d illegal for CNT_WIDTH=%0d",
           DEBOUNCE_CYCLES, CNT_WIDTH);
  end

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_level;
  logic                 r_chg;
  logic                 r_state;
  logic [CNT_WIDTH-1:0] r_cnt;

  logic w_differs;
  logic w_at_last;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its source (sync1 -> sync2 ordering).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_differs = r_sync2 ^ r_level;

  // In IDLE the count is known to be zero, so only a one-edge filter can
  // fire straight from IDLE; in COUNT the live count decides.
  assign w_at_last = (r_state == ST_IDLE) ? (LAST_CNT == '0) : (r_cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= 1'b0;
      r_chg   <= 1'b0;
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else if (!w_differs) begin
      // Agreement (including a bounce back) restarts qualification.
      r_chg   <= 1'b0;
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else if (w_at_last) begin
      r_level <= r_sync2;
      r_chg   <= 1'b1;
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_chg   <= 1'b0;
      r_state <= ST_COUNT;
      r_cnt   <= r_cnt + CNT_WIDTH'(1);
    end
  end

  assign o_level = r_level;
  assign o_chg   = r_chg;
  assign o_sync  = r_sync2;

endmodule : debounce_channel

// File: rtl/dual_input_debouncer.sv
// ---------------------------------------------------------------------------
// dual_input_debouncer
//   Two independent debounce lanes producing glitch-free levels a and b for
//   the downstream two-input gate stage, plus per-lane change pulses and a
//   combined stable flag.
//
// Ports
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   raw_a   in   raw asynchronous level, channel A
//   raw_b   in   raw asynchronous level, channel B
//   a       out  debounced level A (registered)
//   b       out  debounced level B (registered)
//   a_chg   out  one-cycle pulse after a updates
//   b_chg   out  one-cycle pulse after b updates
//   stable  out  1 when neither lane has a pending change
// ---------------------------------------------------------------------------
module dual_input_debouncer
  import dual_input_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_WIDTH       = DEF_CNT_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_a,
  input  logic raw_b,
  output logic a,
  output logic b,
  output logic a_chg,
  output logic b_chg,
  output logic stable
);

  logic w_sync_a;
  logic w_sync_b;

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_WIDTH       (CNT_WIDTH)
  ) u_chan_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_raw   (raw_a),
    .o_level (a),
    .o_chg   (a_chg),
    .o_sync  (w_sync_a)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_WIDTH       (CNT_WIDTH)
  ) u_chan_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_raw   (raw_b),
    .o_level (b),
    .o_chg   (b_chg),
    .o_sync  (w_sync_b)
  );

  // Synchronizers and outputs all reset to 0, so this reads 1 during reset.
  assign stable = (w_sync_a == a) && (w_sync_b == b);

endmodule : dual_input_debouncer

// File: tb/tb_dual_input_debouncer.sv
// ---------------------------------------------------------------------------
// tb_dual_input_debouncer
//   Directed bench for dual_input_debouncer with DEBOUNCE_CYCLES = 4.
//   Outputs are packed as {a, b, a_chg, b_chg, stable} and sampled 1 ns after
//   each rising edge; edge 0 is the first edge that samples a new raw level.
// ---------------------------------------------------------------------------
module tb_dual_input_debouncer;

  logic clk;
  logic rst_n;
  logic raw_a;
  logic raw_b;
  logic a;
  logic b;
  logic a_chg;
  logic b_chg;
  logic stable;

  int n_checks = 0;
  int n_fail   = 0;

  dual_input_debouncer #(
    .DEBOUNCE_CYCLES (4),
    .CNT_WIDTH       (16)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw_a  (raw_a),
    .raw_b  (raw_b),
    .a      (a),
    .b      (b),
    .a_chg  (a_chg),
    .b_chg  (b_chg),
    .stable (stable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ra;
    logic       rb;
    logic [4:0] exp;  // {a, b, a_chg, b_chg, stable}
  } vec_t;

  vec_t vecs [14];

  function automatic logic [4:0] outs();
    return {a, b, a_chg, b_chg, stable};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset with both raw inputs low, leaving everything idle and stable.
  task automatic quiet_reset();
    raw_a = 1'b0;
    raw_b = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    int pulses;

    rst_n = 1'b1;
    raw_a = 1'b0;
    raw_b = 1'b0;

    // Table: raw_a rise through full latency, then a 3-cycle raw_b pulse
    // that reaches a count of 3 but never qualifies.
    vecs[0]  = '{1'b1, 1'b0, 5'b00001};
    vecs[1]  = '{1'b1, 1'b0, 5'b00000};
    vecs[2]  = '{1'b1, 1'b0, 5'b00000};
    vecs[3]  = '{1'b1, 1'b0, 5'b00000};
    vecs[4]  = '{1'b1, 1'b0, 5'b00000};
    vecs[5]  = '{1'b1, 1'b0, 5'b10101};
    vecs[6]  = '{1'b1, 1'b0, 5'b10001};
    vecs[7]  = '{1'b1, 1'b1, 5'b10001};
    vecs[8]  = '{1'b1, 1'b1, 5'b10000};
    vecs[9]  = '{1'b1, 1'b1, 5'b10000};
    vecs[10] = '{1'b1, 1'b0, 5'b10000};
    vecs[11] = '{1'b1, 1'b0, 5'b10001};
    vecs[12] = '{1'b1, 1'b0, 5'b10001};
    vecs[13] = '{1'b1, 1'b0, 5'b10001};

    #2;

    // --- Reset with raw inputs high, then full-latency rise of both ---
    raw_a = 1'b1;
    raw_b = 1'b1;
    rst_n = 1'b0;
    #1;
    check("reset_immediate", outs(), 5'b00001);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("reset_hold_%0d", i), outs(), 5'b00001);
    end
    rst_n = 1'b1;
    for (int e = 0; e <= 6; e++) begin
      tick();
      if (e == 0)      check($sformatf("post_rst_e%0d", e), outs(), 5'b00001);
      else if (e < 5)  check($sformatf("post_rst_e%0d", e), outs(), 5'b00000);
      else if (e == 5) check($sformatf("post_rst_e%0d", e), outs(), 5'b11111);
      else             check($sformatf("post_rst_e%0d", e), outs(), 5'b11001);
    end

    // --- Table-driven: single-channel rise and short-pulse rejection ---
    quiet_reset();
    for (int i = 0; i < 14; i++) begin
      raw_a = vecs[i].ra;
      raw_b = vecs[i].rb;
      tick();
      check($sformatf("vec_%0d", i), outs(), vecs[i].exp);
    end

    // --- Bounce: six toggles, final rise sampled at edge k ---
    quiet_reset();
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      raw_a = (i % 2 == 0);
      tick();
      pulses += int'(a_chg);
      check($sformatf("bounce_t%0d", i), {30'd0, a, a_chg}, 32'd0);
    end
    raw_a = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      tick();
      pulses += int'(a_chg);
      if (k < 5)       check($sformatf("bounce_k%0d", k), {30'd0, a, a_chg}, 32'd0);
      else if (k == 5) check($sformatf("bounce_k%0d", k), {30'd0, a, a_chg}, 32'd3);
      else             check($sformatf("bounce_k%0d", k), {30'd0, a, a_chg}, 32'd2);
    end
    check("bounce_pulse_count", pulses, 32'd1);

    // --- Simultaneous rise on both channels ---
    quiet_reset();
    raw_a = 1'b1;
    raw_b = 1'b1;
    for (int e = 0; e <= 6; e++) begin
      tick();
      if (e == 0)      check($sformatf("both_e%0d", e), outs(), 5'b00001);
      else if (e < 5)  check($sformatf("both_e%0d", e), outs(), 5'b00000);
      else if (e == 5) check($sformatf("both_e%0d", e), outs(), 5'b11111);
      else             check($sformatf("both_e%0d", e), outs(), 5'b11001);
    end

    // --- Reset mid-count between edges 3 and 4, then full latency again ---
    quiet_reset();
    raw_a = 1'b1;
    for (int e = 0; e <= 3; e++) begin
      tick();
      check($sformatf("midrst_pre_e%0d", e), {31'd0, a}, 32'd0);
    end
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_async", outs(), 5'b00001);
    tick();
    tick();
    check("midrst_hold", outs(), 5'b00001);
    rst_n = 1'b1;
    for (int e = 0; e <= 6; e++) begin
      tick();
      if (e < 5)       check($sformatf("midrst_post_e%0d", e), {30'd0, a, a_chg}, 32'd0);
      else if (e == 5) check($sformatf("midrst_post_e%0d", e), {30'd0, a, a_chg}, 32'd3);
      else             check($sformatf("midrst_post_e%0d", e), {30'd0, a, a_chg}, 32'd2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_dual_input_debouncer
